// File: rtl/lbist_ctrl_pkg.sv
// lbist_ctrl_pkg: shared state encoding, default sizes and width helper for the LBIST sequencer
package lbist_ctrl_pkg;
   localparam int DEF_CHAIN_LEN = 20;
   localparam int DEF_NUM_PATTERNS = 100;
   localparam int DEF_SIG_W = 21;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      SHIFT   = 3'd2,
      CAPTURE = 3'd3,
      UNLOAD  = 3'd4,
      COMPARE = 3'd5,
      DONE    = 3'd6
   } state_e;
   function automatic int cnt_w(int max);
      return max > 1 ? $clog2(max) : 1;
   endfunction
endpackage

// File: rtl/lbist_ctrl_if.sv
// lbist_ctrl_if: test-mode controller handshake plus LBIST datapath controls
interface lbist_ctrl_if import lbist_ctrl_pkg::*; #(
   parameter int SIG_W = DEF_SIG_W,
   parameter int PAT_W = $clog2(DEF_NUM_PATTERNS + 1)
);
   logic             start;
   logic             abort;
   logic [SIG_W-1:0] misr_sig;
   logic             pg_init;
   logic             lfsr_en;
   logic             scan_en;
   logic             misr_clr;
   logic             misr_en;
   logic             busy;
   logic             done;
   logic             pass;
   logic [PAT_W-1:0] pat_idx;
   modport master (
      input  start, abort, misr_sig,
      output pg_init, lfsr_en, scan_en, misr_clr, misr_en, busy, done, pass, pat_idx
   );
   modport slave (
      output start, abort, misr_sig,
      input  pg_init, lfsr_en, scan_en, misr_clr, misr_en, busy, done, pass, pat_idx
   );
endinterface

// File: rtl/lbist_ctrl_counter.sv
// lbist_counter: up-counter with clear priority, saturating at MAX, tc flags MAX-1
module lbist_counter #(
   parameter int WIDTH = 1,
   parameter int MAX = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             tc
);
   logic [WIDTH-1:0] count_q, count_d;
   always_comb count_d = clr ? '0 : (en && 32'(count_q) != MAX) ? count_q + WIDTH'(1) : count_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else count_q <= count_d;
   end
   assign count = count_q;
   assign tc = 32'(count_q) == MAX - 1;
endmodule

// File: rtl/lbist_ctrl.sv
// lbist_ctrl: sequences LFSR load, capture, unload and MISR signature compare for logic BIST
module lbist_ctrl import lbist_ctrl_pkg::*; #(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int NUM_PATTERNS = DEF_NUM_PATTERNS,
   parameter int SIG_W = DEF_SIG_W,
   parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   lbist_ctrl_if.master bus
);
   localparam int SW = cnt_w(CHAIN_LEN);
   localparam int PW = $clog2(NUM_PATTERNS + 1);
   state_e state_q, state_d;
   logic pass_q, pass_d, clr_all, in_shift, shift_tc, pat_tc;
   logic [SW-1:0] shift_cnt;
   logic [PW-1:0] pat_cnt;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = INIT;
         INIT:    state_d = SHIFT;
         SHIFT:   if (shift_tc) state_d = CAPTURE;
         CAPTURE: state_d = pat_tc ? UNLOAD : SHIFT;
         UNLOAD:  if (shift_tc) state_d = COMPARE;
         COMPARE: state_d = DONE;
         DONE:    if (bus.start) state_d = INIT;
         default: state_d = IDLE;
      endcase
      if (bus.abort) state_d = IDLE;
      // clearing on entry to INIT means a rerun never shows the stale result
      clr_all = bus.abort || state_d == INIT;
      pass_d = clr_all ? 1'b0 : state_q == COMPARE ? bus.misr_sig == GOLDEN_SIG : pass_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pass_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pass_q <= pass_d;
      end
   end
   assign in_shift = state_q == SHIFT || state_q == UNLOAD;
   lbist_counter #(.WIDTH(SW), .MAX(CHAIN_LEN)) u_shift_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clr_all || (in_shift && shift_tc)), .en(in_shift),
      .count(shift_cnt), .tc(shift_tc)
   );
   lbist_counter #(.WIDTH(PW), .MAX(NUM_PATTERNS)) u_pat_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clr_all), .en(state_q == CAPTURE),
      .count(pat_cnt), .tc(pat_tc)
   );
   assert property (@(posedge clk) disable iff (!rst_n) 32'(shift_cnt) < CHAIN_LEN);
   assign bus.pg_init = state_q == INIT;
   assign bus.misr_clr = state_q == INIT;
   assign bus.lfsr_en = state_q == SHIFT;
   assign bus.scan_en = in_shift;
   // the first load shifts out unknown chain contents, so it is kept out of the MISR
   assign bus.misr_en = (state_q == SHIFT && pat_cnt != '0) || state_q == UNLOAD;
   assign bus.busy = !(state_q inside {IDLE, DONE});
   assign bus.done = state_q == DONE;
   assign bus.pass = pass_q;
   assign bus.pat_idx = pat_cnt;
endmodule
